// File: rtl/fifo_unpacker_pkg.sv
// Shared types for the FIFO-to-stream unpacker.
// The controller state encoding is the output-valid flag itself.
package fifo_unpacker_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

endpackage : fifo_unpacker_pkg

// File: rtl/fifo_unpacker.sv
// Pops wide words from a fall-through FIFO and emits them as narrow valid/ready beats.
// Refills on the cycle the last beat is accepted, so consecutive words have no bubble.
module fifo_unpacker
  import fifo_unpacker_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 f_empty,
  input  logic [IN_WIDTH-1:0]  f_data,
  output logic                 f_inc,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_last
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = $clog2(RATIO);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

  generate
    if (RATIO < 2 || (IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_params
      $error("fifo_unpacker: IN_WIDTH must be an exact multiple (>= 2x) of OUT_WIDTH");
    end
  endgenerate

  state_e                r_state;
  logic [IN_WIDTH-1:0]   r_word;
  logic [CNT_W-1:0]      r_beat;

  state_e                w_state_nxt;
  logic [IN_WIDTH-1:0]   w_word_nxt;
  logic [CNT_W-1:0]      w_beat_nxt;
  logic [IN_WIDTH-1:0]   w_word_shifted;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_load;

  assign m_valid = (r_state == ST_EMIT);
  assign m_last  = m_valid & (r_beat == LAST_BEAT);
  assign m_data  = LSB_FIRST ? r_word[OUT_WIDTH-1:0] : r_word[IN_WIDTH-1 -: OUT_WIDTH];

  assign w_word_shifted = LSB_FIRST ? (r_word >> OUT_WIDTH) : (r_word << OUT_WIDTH);

  assign w_accept = m_valid & m_ready;
  assign w_done   = w_accept & (r_beat == LAST_BEAT);
  assign w_load   = ~f_empty & (~m_valid | w_done);
  // Gated by reset so a FIFO word is never lost to a pop that reset discards.
  assign f_inc    = w_load & rst_n;

  always_comb begin
    // NOTE: defaults are assigned first so every path drives each signal and no latch is inferred.
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_beat_nxt  = r_beat;
    if (w_load) begin
      w_state_nxt = ST_EMIT;
      w_word_nxt  = f_data;
      w_beat_nxt  = '0;
    end else if (w_accept) begin
      if (w_done) begin
        w_state_nxt = ST_IDLE;
      end else begin
        w_word_nxt = w_word_shifted;
        w_beat_nxt = r_beat + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the edge.
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_word  <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

endmodule : fifo_unpacker

// File: tb/tb_fifo_unpacker.sv
// Directed bench for fifo_unpacker: a queue models the fall-through FIFO, a monitor scores every beat.
// A second instance with LSB_FIRST=0 covers MSB-first ordering.
module tb_fifo_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_empty, f_inc, m_valid, m_ready, m_last;
  logic [31:0] f_data;
  logic [7:0]  m_data;

  logic        f_empty_b, f_inc_b, m_valid_b, m_ready_b, m_last_b;
  logic [31:0] f_data_b;
  logic [7:0]  m_data_b;

  int n_cmp = 0;
  int n_err = 0;
  int pops  = 0;

  logic [31:0] fifo_q[$];
  logic [8:0]  exp_q[$];   // {last, data}

  always #5 clk = ~clk;

  fifo_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .f_empty(f_empty), .f_data(f_data), .f_inc(f_inc),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  fifo_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .f_empty(f_empty_b), .f_data(f_data_b), .f_inc(f_inc_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b), .m_last(m_last_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    f_empty = (fifo_q.size() == 0);
    f_data  = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), w[8*k +: 8]});
    refresh();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Monitor and FIFO model: score accepted beats at the falling edge, retire pops after the rising edge.
  initial begin : monitor
    logic       pend;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [8:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      pend = f_inc;
      if (rst_n) begin
        check("pop_when_empty", f_inc & f_empty, 0);
        check("pop_early", f_inc & m_valid & ~(m_ready & m_last), 0);
        if (prev_stall) begin
          check("stall_data", m_data, prev_data);
          check("stall_last", m_last, prev_last);
        end
        if (m_valid & m_ready) begin
          check("beat_expected", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("beat_data", m_data, e[7:0]);
            check("beat_last", m_last, e[8]);
          end
        end
        prev_stall = m_valid & ~m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end else begin
        prev_stall = 1'b0;
      end
      @(posedge clk);
      #1;
      if (pend) begin
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        pops++;
        refresh();
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int p0;
    int c;
    bit drained;

    rst_n     = 1'b0;
    m_ready   = 1'b0;
    f_empty_b = 1'b1;
    f_data_b  = 32'h0;
    m_ready_b = 1'b0;
    refresh();

    // Reset holds everything quiet even with a word waiting in the FIFO.
    push(32'hAABBCCDD);
    tick();
    repeat (3) begin
      neg();
      check("rst_f_inc", f_inc, 0);
      check("rst_valid", m_valid, 0);
      check("rst_data", m_data, 0);
      check("rst_last", m_last, 0);
      check("rst_b_valid", m_valid_b, 0);
    end
    tick();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    neg();
    check("rel_pop", f_inc, 1);
    check("rel_lat", m_valid, 0);
    c = 0;
    while (!(fifo_q.size() == 0 && exp_q.size() == 0 && !m_valid) && c < 20) begin
      neg();
      c++;
    end
    check("rel_drain", (c < 20), 1);
    tick();

    // Single word, one-cycle latency, beats on consecutive cycles.
    p0 = pops;
    push(32'h44332211);
    neg();
    check("sw_pop", f_inc, 1);
    check("sw_lat", m_valid, 0);
    for (int i = 0; i < 4; i++) begin
      neg();
      check("sw_valid", m_valid, 1);
      check("sw_data", m_data, 32'(8'h11 * (i + 1)));
      check("sw_last", m_last, (i == 3));
      check("sw_nopop", f_inc, 0);
    end
    neg();
    check("sw_idle", m_valid, 0);
    check("sw_pops", pops - p0, 1);
    tick();

    // Back-to-back words: refill on the last beat, no gap.
    p0 = pops;
    push(32'h04030201);
    push(32'h08070605);
    neg();
    check("b2b_pop0", f_inc, 1);
    for (int i = 0; i < 8; i++) begin
      neg();
      check("b2b_valid", m_valid, 1);
      check("b2b_data", m_data, 32'(i + 1));
      check("b2b_last", m_last, (i == 3 || i == 7));
      check("b2b_pop", f_inc, (i == 3));
    end
    neg();
    check("b2b_idle", m_valid, 0);
    check("b2b_pops", pops - p0, 2);
    tick();

    // MSB-first instance.
    f_empty_b = 1'b0;
    f_data_b  = 32'h11223344;
    m_ready_b = 1'b1;
    neg();
    check("msb_pop", f_inc_b, 1);
    check("msb_lat", m_valid_b, 0);
    tick();
    f_empty_b = 1'b1;
    f_data_b  = 32'h0;
    for (int i = 0; i < 4; i++) begin
      neg();
      check("msb_valid", m_valid_b, 1);
      check("msb_data", m_data_b, 32'(8'h11 * (i + 1)));
      check("msb_last", m_last_b, (i == 3));
      check("msb_nopop", f_inc_b, 0);
    end
    neg();
    check("msb_idle", m_valid_b, 0);
    tick();

    // Random backpressure over 64 random words.
    p0 = pops;
    for (int w = 0; w < 64; w++) push($urandom);
    c = 0;
    drained = 1'b0;
    while (!drained && c < 3000) begin
      tick();
      m_ready = 1'($urandom_range(0, 1));
      c++;
      drained = (fifo_q.size() == 0 && exp_q.size() == 0 && !m_valid);
    end
    check("bp_drain", drained, 1);
    check("bp_pops", pops - p0, 64);
    m_ready = 1'b1;
    tick();

    // Reset after beat 1 discards the rest of the word.
    push(32'hDDCCBBAA);
    neg();
    check("mw_pop", f_inc, 1);
    neg();
    check("mw_b0", m_data, 32'hAA);
    neg();
    check("mw_b1", m_data, 32'hBB);
    tick();
    rst_n   = 1'b0;
    m_ready = 1'b0;
    exp_q.delete();
    tick();
    neg();
    check("mw_rst_valid", m_valid, 0);
    check("mw_rst_pop", f_inc, 0);
    tick();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    push(32'h00000055);
    neg();
    check("mw_pop2", f_inc, 1);
    for (int i = 0; i < 4; i++) begin
      neg();
      check("mw_valid", m_valid, 1);
      check("mw_data", m_data, (i == 0) ? 32'h55 : 32'h0);
      check("mw_last", m_last, (i == 3));
    end
    neg();
    check("mw_idle", m_valid, 0);
    tick();
    check("mw_exp_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fifo_unpacker
